// File: rtl/snake_pkg.sv
// snake_pkg: screen geometry, colours, reader states and address helper shared by the snake blocks
package snake_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int CELL = 4;
  localparam int COLOR_W = 3;
  localparam int CIDX_W = $clog2(CELL);
  localparam int CNT_W = $clog2(CELL * CELL) + 1;
  localparam logic [COLOR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOR_W-1:0] SNAKE = 3'b010;
  localparam logic [COLOR_W-1:0] FOOD = 3'b100;
  localparam logic [COLOR_W-1:0] WALL = 3'b111;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} reader_state_t;
  // y*160 + x using shifts only
  function automatic logic [14:0] xy_to_addr(input logic [7:0] x, input logic [6:0] y);
    return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
  endfunction
endpackage

// File: rtl/cell_block_reader_if.sv
// cell_block_reader_if: request/result and framebuffer read bus of the block reader
interface cell_block_reader_if;
  import snake_pkg::*;
  logic go;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [COLOR_W-1:0] target_color;
  logic [14:0] mem_addr;
  logic mem_ren;
  logic [COLOR_W-1:0] mem_rdata;
  logic busy;
  logic done;
  logic hit;
  logic [CNT_W-1:0] hit_count;
  modport master (output go, x_in, y_in, target_color, mem_rdata,
                  input mem_addr, mem_ren, busy, done, hit, hit_count);
  modport slave (input go, x_in, y_in, target_color, mem_rdata,
                 output mem_addr, mem_ren, busy, done, hit, hit_count);
endinterface

// File: rtl/cell_scan_counter.sv
// cell_scan_counter: row-major-within-column block scan counter, exposing the next slot and a last flag
module cell_scan_counter #(
  parameter int CELL = 4,
  parameter int W = $clog2(CELL)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic [W-1:0] row_nxt,
  output logic [W-1:0] col_nxt,
  output logic last
);
  logic [W-1:0] row, col;
  always_comb begin
    row_nxt = row + W'(1);
    col_nxt = &row ? col + W'(1) : col;
    last = &{row, col};
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      row <= row_nxt;
      col <= col_nxt;
    end
endmodule

// File: rtl/cell_block_reader.sv
// cell_block_reader: scans one CELLxCELL framebuffer block and counts pixels equal to a target colour
module cell_block_reader import snake_pkg::*; (
  input logic clk,
  input logic reset_n,
  cell_block_reader_if.slave bus
);
  reader_state_t state;
  logic [7:0] x_lat, px;
  logic [6:0] y_lat, py;
  logic [COLOR_W-1:0] tgt;
  logic [CIDX_W-1:0] row_nxt, col_nxt;
  logic last, vld, clip;
  logic [14:0] addr_nxt;
  cell_scan_counter #(.CELL(CELL)) u_cnt (
    .clk(clk), .reset_n(reset_n), .en(state == READ),
    .row_nxt(row_nxt), .col_nxt(col_nxt), .last(last)
  );
  // the address register runs one slot ahead of the counter, so slot 0 comes straight from the request
  always_comb begin
    px = state == IDLE ? bus.x_in : x_lat + 8'(col_nxt);
    py = state == IDLE ? bus.y_in : y_lat + 7'(row_nxt);
    clip = (px >= 8'(SCREEN_W)) || (py >= 7'(SCREEN_H));
    addr_nxt = clip ? '0 : xy_to_addr(px, py);
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      x_lat <= '0;
      y_lat <= '0;
      tgt <= '0;
      vld <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_ren <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hit <= 1'b0;
      bus.hit_count <= '0;
    end else begin
      vld <= bus.mem_ren;
      bus.done <= 1'b0;
      if (vld && bus.mem_rdata == tgt) begin
        bus.hit <= 1'b1;
        bus.hit_count <= bus.hit_count + CNT_W'(1);
      end
      case (state)
        IDLE: if (bus.go) begin
          x_lat <= bus.x_in;
          y_lat <= bus.y_in;
          tgt <= bus.target_color;
          bus.hit <= 1'b0;
          bus.hit_count <= '0;
          bus.busy <= 1'b1;
          bus.mem_addr <= addr_nxt;
          bus.mem_ren <= !clip;
          state <= READ;
        end
        READ: begin
          bus.mem_addr <= last ? '0 : addr_nxt;
          bus.mem_ren <= !last && !clip;
          state <= last ? DRAIN : READ;
        end
        DRAIN: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cell_block_reader.sv
// tb_cell_block_reader: table-driven block scans against a framebuffer model with a read-address scoreboard
module tb_cell_block_reader;
  import snake_pkg::*;
  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [COLOR_W-1:0] tgt;
    int fx, fy, fw, fh;
    logic [COLOR_W-1:0] fc;
    int hits, reads;
  } vec_t;
  typedef struct {
    int addr;
    bit ren;
  } rd_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [COLOR_W-1:0] fb [SCREEN_W*SCREEN_H];
  logic [COLOR_W-1:0] idle_data = '0;
  rd_t q[$];
  vec_t vecs[6];
  int errors = 0;
  int checks = 0;
  cell_block_reader_if bus();
  cell_block_reader dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  always #5 clk = ~clk;
  // unread slots return the target colour so a clipped slot that were counted would show up
  always @(posedge clk) bus.mem_rdata <= bus.mem_ren ? fb[bus.mem_addr] : idle_data;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fill(input vec_t v);
    foreach (fb[i]) fb[i] = BLACK;
    for (int x = v.fx; x < v.fx + v.fw; x++)
      for (int y = v.fy; y < v.fy + v.fh; y++) fb[y*SCREEN_W + x] = v.fc;
  endtask

  task automatic scan(input vec_t v, input bit extra_go, input int rst_at);
    rd_t e;
    int reads = 0;
    for (int c = 0; c < CELL; c++)
      for (int r = 0; r < CELL; r++) begin
        int xx = (int'(v.x) + c) % 256;
        int yy = (int'(v.y) + r) % 128;
        bit cl = xx >= SCREEN_W || yy >= SCREEN_H;
        q.push_back('{cl ? 0 : yy*SCREEN_W + xx, !cl});
      end
    idle_data = v.tgt;
    bus.go = 1'b1;
    bus.x_in = v.x;
    bus.y_in = v.y;
    bus.target_color = v.tgt;
    @(posedge clk);
    #1;
    bus.go = 1'b0;
    bus.x_in = ~v.x;
    bus.y_in = ~v.y;
    bus.target_color = ~v.tgt;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (rst_at != 0 && c == rst_at + 1) begin
        chk("rst_outputs", int'({bus.done, bus.busy, bus.mem_ren, bus.hit, bus.hit_count, bus.mem_addr}), 0);
        reset_n = 1'b1;
        repeat (20) begin
          @(negedge clk);
          chk("post_rst_idle", int'({bus.done, bus.busy, bus.mem_ren, bus.hit, bus.hit_count}), 0);
        end
        q.delete();
        return;
      end
      if (c <= CELL*CELL) begin
        e = q.pop_front();
        chk($sformatf("rd_slot%0d", c - 1), int'({bus.mem_ren, bus.mem_addr}), int'(e.ren) * 32768 + e.addr);
      end else chk("ren_after_scan", int'(bus.mem_ren), 0);
      chk("busy", int'(bus.busy), int'(c <= CELL*CELL + 1));
      chk("done", int'(bus.done), int'(c == CELL*CELL + 2));
      reads += int'(bus.mem_ren);
      if (c >= CELL*CELL + 2) begin
        chk("hit_count", int'(bus.hit_count), v.hits);
        chk("hit", int'(bus.hit), int'(v.hits != 0));
      end
      if (c == CELL*CELL + 2) chk("read_count", reads, v.reads);
      if (extra_go && (c == 5 || c == 18)) bus.go = 1'b1;
      if (extra_go && c == 6) bus.go = 1'b0;
      if (c == rst_at) reset_n = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{8'd10, 7'd20, SNAKE, 0, 0, 0, 0, BLACK, 0, 16};
    vecs[1] = '{8'd10, 7'd20, SNAKE, 12, 22, 1, 1, SNAKE, 1, 16};
    vecs[2] = '{8'd10, 7'd20, SNAKE, 10, 20, 4, 4, SNAKE, 16, 16};
    vecs[3] = '{8'd158, 7'd118, FOOD, 150, 110, 10, 10, FOOD, 4, 4};
    vecs[4] = '{8'd255, 7'd20, WALL, 0, 20, 1, 4, WALL, 4, 12};
    vecs[5] = '{8'd10, 7'd20, FOOD, 10, 20, 4, 4, SNAKE, 0, 16};
    bus.go = 1'b0;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.target_color = '0;
    fill(vecs[0]);
    repeat (3) @(negedge clk);
    chk("reset_state", int'({bus.done, bus.busy, bus.mem_ren, bus.hit, bus.hit_count, bus.mem_addr}), 0);
    reset_n = 1'b1;
    @(negedge clk);
    foreach (vecs[i]) begin
      fill(vecs[i]);
      scan(vecs[i], 1'b0, 0);
    end
    fill(vecs[1]);
    scan(vecs[1], 1'b1, 0);
    fill(vecs[2]);
    scan(vecs[2], 1'b0, 0);
    scan(vecs[2], 1'b0, 9);
    scan(vecs[2], 1'b0, 0);
    bus.go = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_idle", int'({bus.done, bus.busy, bus.mem_ren}), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
